// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - two-requester round-robin front end for one shared 64x64 signed multiplier
//
// Purpose: accepts one multiply at a time from req0/req1 (round-robin when both are
// valid), registers the operands onto mul_a/mul_b, waits LATENCY edges, captures the
// multiplier's product/overflow, and holds the response until resp_ready.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   reqN_valid/reqN_ready          requester N handshake (ready is combinational)
//   reqN_a/reqN_b                  requester N operands (two's complement)
//   mul_a/mul_b                    registered operands to the shared multiplier
//   mul_product/mul_overflow       multiplier result
//   resp_valid/resp_ready          response handshake
//   resp_id/resp_product/resp_overflow  owner and captured result
//   busy                           block is not idle
//   grant_cnt0/grant_cnt1          saturating accept counters (MUL_SHARE_STATS_EN only)
//
// Configuration: define MUL_SHARE_STATS_EN to add the grant counters.

module mul_share_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [63:0]   req0_a,
  input  logic [63:0]   req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [63:0]   req1_a,
  input  logic [63:0]   req1_b,
  output logic [63:0]   mul_a,
  output logic [63:0]   mul_b,
  input  logic [127:0]  mul_product,
  input  logic          mul_overflow,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_id,
  output logic [127:0]  resp_product,
  output logic          resp_overflow,
  output logic          busy
`ifdef MUL_SHARE_STATS_EN
  ,
  output logic [31:0]   grant_cnt0,
  output logic [31:0]   grant_cnt1
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t         state_q, state_d;
  logic           rr_ptr_q, rr_ptr_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [63:0]    mul_a_q, mul_a_d;
  logic [63:0]    mul_b_q, mul_b_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_id_q, resp_id_d;
  logic [127:0]   resp_product_q, resp_product_d;
  logic           resp_overflow_q, resp_overflow_d;

  logic           gnt0, gnt1, accept;

  // A lone valid requester always wins; on contention rr_ptr picks.
  assign gnt0 = req0_valid & (~req1_valid | ~rr_ptr_q);
  assign gnt1 = req1_valid & (~req0_valid |  rr_ptr_q);

  assign req0_ready = (state_q == ST_IDLE) & gnt0;
  assign req1_ready = (state_q == ST_IDLE) & gnt1;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    cnt_d           = cnt_q;
    mul_a_d         = mul_a_q;
    mul_b_d         = mul_b_q;
    resp_valid_d    = resp_valid_q;
    resp_id_d       = resp_id_q;
    resp_product_d  = resp_product_q;
    resp_overflow_d = resp_overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mul_a_d   = req1_ready ? req1_a : req0_a;
          mul_b_d   = req1_ready ? req1_b : req0_b;
          resp_id_d = req1_ready;
          rr_ptr_d  = ~req1_ready;
          cnt_d     = CNT_INIT;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          resp_product_d  = mul_product;
          resp_overflow_d = mul_overflow;
          resp_valid_d    = 1'b1;
          state_d         = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // Returning to IDLE first costs one cycle but keeps accept off the response edge.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MUL_SHARE_STATS_EN
  logic [31:0] gcnt0_q, gcnt0_d;
  logic [31:0] gcnt1_q, gcnt1_d;

  always_comb begin
    gcnt0_d = gcnt0_q;
    gcnt1_d = gcnt1_q;
    if (req0_ready && (gcnt0_q != 32'hFFFF_FFFF)) gcnt0_d = gcnt0_q + 32'd1;
    if (req1_ready && (gcnt1_q != 32'hFFFF_FFFF)) gcnt1_d = gcnt1_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt0_q <= 32'd0;
      gcnt1_q <= 32'd0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
    end
  end

  assign grant_cnt0 = gcnt0_q;
  assign grant_cnt1 = gcnt1_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      rr_ptr_q        <= 1'b0;
      cnt_q           <= 4'd0;
      mul_a_q         <= 64'd0;
      mul_b_q         <= 64'd0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= 1'b0;
      resp_product_q  <= 128'd0;
      resp_overflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      cnt_q           <= cnt_d;
      mul_a_q         <= mul_a_d;
      mul_b_q         <= mul_b_d;
      resp_valid_q    <= resp_valid_d;
      resp_id_q       <= resp_id_d;
      resp_product_q  <= resp_product_d;
      resp_overflow_q <= resp_overflow_d;
    end
  end

  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_product  = resp_product_q;
  assign resp_overflow = resp_overflow_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
